pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
// - Sequences the 5-stage pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) each cycle.
// - Generates per-stage write enables, the ID/EX bubble request (stall) and the IF/ID squash.
// - Detects load-use hazards, freezes on data-memory wait and squashes on EX redirect.
// - Tracks in-flight instruction fetches across redirects and latches halt.
// - Sits beside the pipeline registers; its stall output drives the ID/EX bubble-insert input.
// PARAMETERS
// - REG_AW   3   register-specifier width
// - CNT_W   16   width of the saturating performance counters
// PORTS
// - clk            in   1      clock; all state on rising edge
// - rst            in   1      reset, asynchronous, active-low
// - id_rs          in   REG_AW source reg A of the instruction in ID
// - id_rt          in   REG_AW source reg B of the instruction in ID
// - id_rs_used     in   1      ID instruction reads id_rs
// - id_rt_used     in   1      ID instruction reads id_rt
// - ex_memtoreg    in   1      instruction in EX is a load
// - ex_dst         in   REG_AW destination reg of EX instruction
// - ex_redirect    in   1      taken branch/jump/siic/rti resolved in EX
// - imem_busy      in   1      instruction memory has not returned the fetch
// - dmem_busy      in   1      data memory access in MEM not complete
// - mem_halt       in   1      halt instruction is in MEM
// - pc_en          out  1      PC write enable
// - ifid_en        out  1      IF/ID write enable
// - ifid_flush     out  1      IF/ID loads NOP instead of fetched word
// - idex_en        out  1      ID/EX write enable
// - idex_stall     out  1      ID/EX loads bubble (NOP, all control bits 0)
// - exmem_en       out  1      EX/MEM write enable
// - memwb_en       out  1      MEM/WB write enable
// - halted         out  1      pipeline permanently stopped
// - stall_cnt      out  CNT_W  cycles with pc_en==0, outside reset and HALTED
// - bubble_cnt     out  CNT_W  cycles with idex_stall==1 && idex_en==1
// BEHAVIOUR
// - States: RUN, MEM_WAIT, HALTED. Flag redir_pend (1 bit). All enable outputs are combinational.
// - Reset (rst==0): state RUN, redir_pend 0, counters 0, halted 0.
//   All enables and flush/stall outputs forced to 0 while rst is low.
// - Per-cycle priority, highest first:
//   1 HALTED: all enables 0, halted=1; left only by reset.
//   2 dmem_busy=1: state MEM_WAIT, all enables 0, idex_stall=0, ifid_flush=0.
//     redir_pend is held. Leave on the first cycle dmem_busy=0 and evaluate rules 3-6 that same cycle.
//   3 ex_redirect=1: all enables 1, ifid_flush=1, idex_stall=1 (2-instruction squash).
//     If imem_busy=1 this cycle, redir_pend<=1 and pc_en stays 1 so the new target is latched.
//   4 load-use: ex_memtoreg && ((id_rs_used && id_rs==ex_dst) || (id_rt_used && id_rt==ex_dst)).
//     pc_en=0, ifid_en=0, idex_stall=1, other enables 1. Exactly one bubble, since the EX load moves on.
//   5 imem_busy=1: pc_en=0, ifid_en=1, ifid_flush=1, other enables 1.
//   6 otherwise all enables 1, flush/stall 0.
// - redir_pend: set by rule 3, cleared on the first cycle with imem_busy=0 and state!=MEM_WAIT.
//   In that clearing cycle ifid_flush=1 (the stale wrong-path word is discarded) and pc_en=1.
// - Halt: mem_halt=1 && memwb_en=1 at a clock edge -> HALTED next cycle.
//   A halt sitting in MEM during a dmem freeze does not halt until the freeze releases.
// - Counters saturate at all-ones and never wrap. They do not count while rst is low or in HALTED.
// - idex_stall is only meaningful when idex_en=1. It is 0 whenever idex_en=0.
// STRUCTURE
// - Shared package: state enum {RUN, MEM_WAIT, HALTED}, NOP_INSTR=16'h0800, REG_AW.
// - One sub-module: sat_counter (CNT_W, inc, async active-low rst), instantiated twice.
// - Hazard compare, priority mux and FSM stay flat in this module.
// TESTING
// - Load-use: ex_memtoreg=1, ex_dst=3, id_rs=3, id_rs_used=1
//   -> 1 cycle pc_en=0, ifid_en=0, idex_stall=1; bubble_cnt=1; next cycle all en=1.
// - dmem_busy held 4 cycles during load-use -> all en=0 for 4 cycles.
//   Then the load-use bubble is issued once; stall_cnt=5.
// - ex_redirect with imem_busy=1 -> ifid_flush=1, idex_stall=1, redir_pend=1.
//   imem_busy drops 3 cycles later -> ifid_flush=1 in that cycle, then normal flow.
// - mem_halt=1 with dmem_busy=1 for 2 cycles -> halted stays 0.
//   halted=1 one cycle after dmem_busy falls; all en=0 thereafter.
// - rst pulled low mid-MEM_WAIT with redir_pend=1 -> all outputs 0 immediately (async).
//   After release: RUN, counters 0, pend cleared.
// - Force stall_cnt near all-ones (CNT_W=4): 20 stalled cycles -> counter sticks at 4'hF.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The state enum, the NOP encoding and the default register-specifier width live here.
package pipe_hazard_ctrl_pkg;

    localparam int REG_AW = 3;
    localparam logic [15:0] NOP_INSTR = 16'h0800;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALTED   = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-low reset.
// It sticks at all-ones and never wraps.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: per-stage enables, ID/EX bubble, IF/ID squash,
// load-use detection, data-memory freeze, redirect/fetch tracking and halt latch.
module pipe_hazard_ctrl #(
    parameter int REG_AW = pipe_hazard_ctrl_pkg::REG_AW,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic              ex_memtoreg,
    input  logic [REG_AW-1:0] ex_dst,
    input  logic              ex_redirect,
    input  logic              imem_busy,
    input  logic              dmem_busy,
    input  logic              mem_halt,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_en,
    output logic              idex_stall,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    import pipe_hazard_ctrl_pkg::*;

    state_t state_reg;
    logic   redir_pend_reg;
    logic   load_use;

    assign load_use = ex_memtoreg &&
                      ((id_rs_used && (id_rs == ex_dst)) ||
                       (id_rt_used && (id_rt == ex_dst)));

    assign halted = (state_reg == HALTED);

    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        idex_en    = 1'b0;
        idex_stall = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        if (rst && (state_reg != HALTED) && !dmem_busy) begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            if (ex_redirect) begin
                ifid_flush = 1'b1;
                idex_stall = 1'b1;
            end else if (redir_pend_reg && !imem_busy) begin
                // Late fetch finally arrived but belongs to the wrong path.
                ifid_flush = 1'b1;
            end else if (load_use) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_stall = 1'b1;
            end else if (imem_busy) begin
                pc_en      = 1'b0;
                ifid_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= RUN;
            redir_pend_reg <= 1'b0;
        end else begin
            case (state_reg)
                HALTED: state_reg <= HALTED;
                default: begin
                    if (dmem_busy) begin
                        state_reg <= MEM_WAIT;
                    end else begin
                        redir_pend_reg <= imem_busy && (redir_pend_reg || ex_redirect);
                        state_reg      <= (mem_halt && memwb_en) ? HALTED : RUN;
                    end
                end
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   ((state_reg != HALTED) && !pc_en),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (idex_stall && idex_en),
        .count (bubble_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, hand sequences for the
// multi-cycle corner cases, and randomized traffic against a rule-level model.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] id_rs, id_rt, ex_dst;
    logic       id_rs_used, id_rt_used, ex_memtoreg, ex_redirect;
    logic       imem_busy, dmem_busy, mem_halt;

    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_stall, exmem_en, memwb_en, halted;
    logic [15:0] stall_cnt, bubble_cnt;
    logic        n_pc_en, n_ifid_en, n_ifid_flush, n_idex_en, n_idex_stall, n_exmem_en;
    logic        n_memwb_en, n_halted;
    logic [3:0]  n_stall_cnt, n_bubble_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_AW(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .ex_memtoreg(ex_memtoreg), .ex_dst(ex_dst), .ex_redirect(ex_redirect),
        .imem_busy(imem_busy), .dmem_busy(dmem_busy), .mem_halt(mem_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
        .idex_stall(idex_stall), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .halted(halted), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    // Narrow-counter copy to reach saturation quickly.
    pipe_hazard_ctrl #(.REG_AW(3), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .ex_memtoreg(ex_memtoreg), .ex_dst(ex_dst), .ex_redirect(ex_redirect),
        .imem_busy(imem_busy), .dmem_busy(dmem_busy), .mem_halt(mem_halt),
        .pc_en(n_pc_en), .ifid_en(n_ifid_en), .ifid_flush(n_ifid_flush), .idex_en(n_idex_en),
        .idex_stall(n_idex_stall), .exmem_en(n_exmem_en), .memwb_en(n_memwb_en),
        .halted(n_halted), .stall_cnt(n_stall_cnt), .bubble_cnt(n_bubble_cnt)
    );

    typedef struct packed {
        logic [2:0] rs;
        logic       rs_used;
        logic [2:0] rt;
        logic       rt_used;
        logic       memtoreg;
        logic [2:0] dst;
        logic       redirect;
        logic       imem;
        logic       dmem;
        logic       halt;
    } ins_t;

    typedef struct packed {
        logic pc_en, ifid_en, ifid_flush, idex_en, idex_stall, exmem_en, memwb_en, halted;
    } outs_t;

    typedef struct {
        string name;
        ins_t  i;
        outs_t o;
    } vec_t;

    localparam outs_t O_ZERO  = 8'b0000_0000;
    localparam outs_t O_ALL   = 8'b1101_0110;
    localparam outs_t O_LU    = 8'b0001_1110;
    localparam outs_t O_IMEM  = 8'b0111_0110;
    localparam outs_t O_REDIR = 8'b1111_1110;
    localparam outs_t O_CLR   = 8'b1111_0110;
    localparam outs_t O_HALT  = 8'b0000_0001;

    int checks = 0;
    int failures = 0;

    // Reference model state: plain flags and unbounded counts.
    bit m_halted, m_pend;
    int m_stall, m_bubble;

    function automatic ins_t mk(int rs, int rs_used, int rt, int rt_used, int memtoreg,
                                int dst, int redirect, int imem, int dmem, int halt);
        ins_t r;
        r.rs = 3'(rs); r.rs_used = 1'(rs_used); r.rt = 3'(rt); r.rt_used = 1'(rt_used);
        r.memtoreg = 1'(memtoreg); r.dst = 3'(dst); r.redirect = 1'(redirect);
        r.imem = 1'(imem); r.dmem = 1'(dmem); r.halt = 1'(halt);
        return r;
    endfunction

    function automatic int sat(int v, int w);
        int mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic outs_t dut_outs();
        return {pc_en, ifid_en, ifid_flush, idex_en, idex_stall, exmem_en, memwb_en, halted};
    endfunction

    function automatic outs_t dut4_outs();
        return {n_pc_en, n_ifid_en, n_ifid_flush, n_idex_en, n_idex_stall, n_exmem_en,
                n_memwb_en, n_halted};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Outputs implied by the priority rules for the current model situation.
    function automatic outs_t model_outs(ins_t i);
        outs_t o = O_ZERO;
        bit lu;
        if (m_halted) return O_HALT;
        if (i.dmem) return O_ZERO;
        lu = i.memtoreg && ((i.rs_used && i.rs == i.dst) || (i.rt_used && i.rt == i.dst));
        if (i.redirect)            o = O_REDIR;
        else if (m_pend && !i.imem) o = O_CLR;
        else if (lu)               o = O_LU;
        else if (i.imem)           o = O_IMEM;
        else                       o = O_ALL;
        return o;
    endfunction

    task automatic model_edge(input ins_t i, input outs_t o);
        if (m_halted) return;
        if (!o.pc_en) m_stall++;
        if (o.idex_stall && o.idex_en) m_bubble++;
        if (!i.dmem) begin
            m_pend = i.imem && (m_pend || i.redirect);
            if (i.halt && o.memwb_en) m_halted = 1'b1;
        end
    endtask

    task automatic set_inputs(input ins_t i);
        id_rs = i.rs; id_rs_used = i.rs_used; id_rt = i.rt; id_rt_used = i.rt_used;
        ex_memtoreg = i.memtoreg; ex_dst = i.dst; ex_redirect = i.redirect;
        imem_busy = i.imem; dmem_busy = i.dmem; mem_halt = i.halt;
    endtask

    // One clock: drive at posedge+1, compare at negedge, advance model at posedge.
    task automatic cycle(input ins_t i, input string tag, input bit has_exp, input outs_t exp);
        outs_t mo;
        set_inputs(i);
        @(negedge clk);
        mo = model_outs(i);
        if (has_exp) chk({tag, " table"}, int'(dut_outs()), int'(exp));
        chk({tag, " outs"}, int'(dut_outs()), int'(mo));
        chk({tag, " outs4"}, int'(dut4_outs()), int'(mo));
        chk({tag, " stall_cnt"}, int'(stall_cnt), sat(m_stall, 16));
        chk({tag, " bubble_cnt"}, int'(bubble_cnt), sat(m_bubble, 16));
        chk({tag, " stall_cnt4"}, int'(n_stall_cnt), sat(m_stall, 4));
        chk({tag, " bubble_cnt4"}, int'(n_bubble_cnt), sat(m_bubble, 4));
        $display("cycle %s in=%h out=%h stall=%0d bubble=%0d", tag, i, dut_outs(),
                 stall_cnt, bubble_cnt);
        model_edge(i, mo);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        ins_t idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #2;
        chk({tag, " rst outs"}, int'(dut_outs()), 0);
        chk({tag, " rst outs4"}, int'(dut4_outs()), 0);
        chk({tag, " rst stall_cnt"}, int'(stall_cnt), 0);
        chk({tag, " rst bubble_cnt"}, int'(bubble_cnt), 0);
        $display("reset %s out=%h", tag, dut_outs());
        set_inputs(idle);
        m_halted = 0; m_pend = 0; m_stall = 0; m_bubble = 0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        model_edge(idle, model_outs(idle));
        #1;
    endtask

    vec_t vecs[$];
    ins_t idle, lu3, ri;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        lu3  = mk(3, 1, 0, 0, 1, 3, 0, 0, 0, 0);
        set_inputs(idle);
        #1;
        do_reset("init");

        vecs.push_back('{"idle",        idle,                               O_ALL});
        vecs.push_back('{"lu_rs",       lu3,                                O_LU});
        vecs.push_back('{"lu_rt",       mk(1, 1, 5, 1, 1, 5, 0, 0, 0, 0),   O_LU});
        vecs.push_back('{"ld_nomatch",  mk(2, 1, 4, 1, 1, 3, 0, 0, 0, 0),   O_ALL});
        vecs.push_back('{"rs_unused",   mk(3, 0, 1, 1, 1, 3, 0, 0, 0, 0),   O_ALL});
        vecs.push_back('{"not_load",    mk(3, 1, 3, 1, 0, 3, 0, 0, 0, 0),   O_ALL});
        vecs.push_back('{"imem",        mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0),   O_IMEM});
        vecs.push_back('{"redir_lu",    mk(3, 1, 0, 0, 1, 3, 1, 0, 0, 0),   O_REDIR});
        vecs.push_back('{"dmem_redir",  mk(3, 1, 0, 0, 1, 3, 1, 0, 1, 0),   O_ZERO});
        vecs.push_back('{"idle2",       idle,                               O_ALL});
        vecs.push_back('{"lu_r0",       mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0),   O_LU});
        vecs.push_back('{"lu_r7",       mk(6, 1, 7, 1, 1, 7, 0, 0, 0, 0),   O_LU});
        vecs.push_back('{"imem_lu",     mk(3, 1, 0, 0, 1, 3, 0, 1, 0, 0),   O_LU});
        foreach (vecs[k]) cycle(vecs[k].i, vecs[k].name, 1'b1, vecs[k].o);

        // Single load-use bubble.
        do_reset("lu");
        cycle(lu3, "lu_seq", 1'b1, O_LU);
        cycle(idle, "lu_after", 1'b1, O_ALL);
        chk("lu bubble_cnt", int'(bubble_cnt), 1);
        chk("lu stall_cnt", int'(stall_cnt), 1);

        // Data-memory freeze over a pending load-use.
        do_reset("dm");
        for (int k = 0; k < 4; k++) cycle(mk(3, 1, 0, 0, 1, 3, 0, 0, 1, 0), "dm_freeze", 1'b1, O_ZERO);
        cycle(lu3, "dm_release", 1'b1, O_LU);
        cycle(idle, "dm_after", 1'b1, O_ALL);
        chk("dm stall_cnt", int'(stall_cnt), 5);
        chk("dm bubble_cnt", int'(bubble_cnt), 1);

        // Redirect while the fetch is outstanding.
        do_reset("rd");
        cycle(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0), "rd_redirect", 1'b1, O_REDIR);
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "rd_wait1", 1'b1, O_IMEM);
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "rd_wait2", 1'b1, O_IMEM);
        cycle(idle, "rd_discard", 1'b1, O_CLR);
        cycle(idle, "rd_normal", 1'b1, O_ALL);

        // Halt held off by a data-memory freeze.
        do_reset("hl");
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1), "hl_frz1", 1'b1, O_ZERO);
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1), "hl_frz2", 1'b1, O_ZERO);
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "hl_release", 1'b1, O_ALL);
        cycle(idle, "hl_halted", 1'b1, O_HALT);
        cycle(lu3, "hl_stays", 1'b1, O_HALT);
        chk("hl stall_cnt", int'(stall_cnt), 2);

        // Reset asserted mid-freeze with a redirect pending.
        do_reset("rp");
        cycle(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0), "rp_redirect", 1'b1, O_REDIR);
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0), "rp_freeze", 1'b1, O_ZERO);
        set_inputs(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        do_reset("rp");
        cycle(idle, "rp_after", 1'b1, O_ALL);
        chk("rp stall_cnt", int'(stall_cnt), 0);

        // Narrow counter saturation.
        do_reset("sat");
        for (int k = 0; k < 20; k++) cycle(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "sat_imem", 1'b1, O_IMEM);
        chk("sat stall_cnt4", int'(n_stall_cnt), 15);
        chk("sat stall_cnt16", int'(stall_cnt), 20);

        // Randomized traffic against the model.
        do_reset("rnd");
        for (int n = 0; n < 3000; n++) begin
            if (m_halted && ($urandom_range(0, 3) == 0)) do_reset("rnd");
            else if ($urandom_range(0, 199) == 0) do_reset("rnd");
            ri = mk($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
                    $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 4) == 0), ($urandom_range(0, 39) == 0));
            cycle(ri, "rnd", 1'b0, O_ZERO);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
